// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//   Scans a ROWS x COLS push-button matrix. One column is driven low at a time
//   for a full column period; the synchronised row lines are sampled on the last
//   cycle of that period and collected into a frame snapshot. Whole frames are
//   debounced (DEBOUNCE identical frames) before the debounced matrix changes.
//   A transition from an empty matrix to exactly one key produces a one-cycle
//   VALID strobe with KEY = row*COLS + col.
//
//   Optional feature (macro KEYPAD_AUTOREPEAT_EN): while a single key is held,
//   VALID re-pulses with the same KEY after REP_DLY frames, then every REP_RATE
//   frames. REP_RATE must not exceed REP_DLY.
//
// Ports
//   clk      in   1     system clock
//   rst      in   1     synchronous reset, active-low
//   ROW      in   ROWS  row sense lines, active-low, asynchronous
//   COL      out  COLS  column drive, active-low, exactly one bit low
//   KEY      out  4     code of last accepted key
//   VALID    out  1     one-cycle strobe for a new key event
//   PRESSED  out  1     debounced matrix non-empty
// -----------------------------------------------------------------------------
module keypad_scan #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int IN_CLOCK = 50_000_000,
    parameter int SCAN_HZ  = 4000,
    parameter int DEBOUNCE = 4,
    parameter int REP_DLY  = 128,
    parameter int REP_RATE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] ROW,
    output logic [COLS-1:0] COL,
    output logic [3:0]      KEY,
    output logic            VALID,
    output logic            PRESSED
);

    localparam int NKEY = ROWS * COLS;
    localparam int DIV  = IN_CLOCK / SCAN_HZ - 1;
    localparam int DW   = (DIV < 1) ? 1 : $clog2(DIV + 1);
    localparam int CW   = (COLS > 2) ? 2 : 1;

    localparam logic [DW-1:0] DIV_MAX    = DW'(DIV);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [3:0]    STABLE_MAX = 4'(DEBOUNCE - 1);

    // True when exactly one bit of the matrix is set.
    function automatic logic one_hot(input logic [NKEY-1:0] v);
        return (v != '0) && ((v & (v - NKEY'(1))) == '0);
    endfunction

    // Code of the lowest set bit (only used on one-hot matrices).
    function automatic logic [3:0] key_code(input logic [NKEY-1:0] v);
        logic [3:0] code;
        code = 4'd0;
        for (int k = NKEY - 1; k >= 0; k--) begin
            if (v[k]) begin
                code = 4'(k);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    logic [ROWS-1:0] row_meta_q, row_sync_q;
    logic [DW-1:0]   div_q, div_d;
    logic [CW-1:0]   col_idx_q, col_idx_d;
    logic [COLS-1:0] col_q, col_d;
    logic [NKEY-1:0] snap_q, snap_d;
    logic [NKEY-1:0] prev_q, prev_d;
    logic [3:0]      stable_q, stable_d;
    logic [NKEY-1:0] deb_q, deb_d;
    logic [3:0]      key_q, key_d;
    logic            valid_q, valid_d;
    logic            pressed_q, pressed_d;

    logic            tick_s;
    logic            frame_end_s;
    logic [NKEY-1:0] snap_merged_s;
    logic [3:0]      stable_next_s;
    logic            deb_upd_s;
    logic            rep_fire_s;

    assign tick_s      = (div_q == DIV_MAX);
    assign frame_end_s = tick_s && (col_idx_q == COL_LAST);

    // Snapshot with the current column's row samples merged in (1 = pressed).
    always_comb begin
        snap_merged_s = snap_q;
        for (int k = 0; k < NKEY; k++) begin
            if (CW'(k % COLS) == col_idx_q) begin
                snap_merged_s[k] = ~row_sync_q[k / COLS];
            end else begin
                snap_merged_s[k] = snap_q[k];
            end
        end
    end

    // Stable-frame counter and debounce decision for the frame just completed.
    always_comb begin
        if (snap_merged_s == prev_q) begin
            if (stable_q == STABLE_MAX) begin
                stable_next_s = stable_q;
            end else begin
                stable_next_s = stable_q + 4'd1;
            end
        end else begin
            stable_next_s = 4'd0;
        end
        deb_upd_s = frame_end_s && (stable_next_s == STABLE_MAX) && (snap_merged_s != deb_q);
    end

    // Divider, column stepping and frame bookkeeping next state.
    always_comb begin
        div_d     = div_q;
        col_idx_d = col_idx_q;
        snap_d    = snap_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        deb_d     = deb_q;
        if (tick_s) begin
            div_d = '0;
            if (col_idx_q == COL_LAST) begin
                col_idx_d = '0;
            end else begin
                col_idx_d = col_idx_q + CW'(1);
            end
            if (frame_end_s) begin
                snap_d   = '0;
                prev_d   = snap_merged_s;
                stable_d = stable_next_s;
                if (deb_upd_s) begin
                    deb_d = snap_merged_s;
                end else begin
                    deb_d = deb_q;
                end
            end else begin
                snap_d = snap_merged_s;
            end
        end else begin
            div_d = div_q + DW'(1);
        end
        for (int c = 0; c < COLS; c++) begin
            col_d[c] = (CW'(c) != col_idx_d);
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REP_DLY + 1);
    logic [RW-1:0] rep_q, rep_d;

    // Repeat frame counter: runs only while one key is held and the matrix is unchanged.
    always_comb begin
        rep_d      = rep_q;
        rep_fire_s = 1'b0;
        if (deb_upd_s || !one_hot(deb_q)) begin
            rep_d = '0;
        end else if (frame_end_s) begin
            if (rep_q == RW'(REP_DLY - 1)) begin
                rep_fire_s = 1'b1;
                // Reload so the next fire comes REP_RATE frames later.
                rep_d      = RW'(REP_DLY - REP_RATE);
            end else begin
                rep_d = rep_q + RW'(1);
            end
        end else begin
            rep_d = rep_q;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // Key event decoding: only empty -> single key reports a press.
    always_comb begin
        key_d = key_q;
        if (deb_upd_s && (deb_q == '0) && one_hot(snap_merged_s)) begin
            valid_d = 1'b1;
            key_d   = key_code(snap_merged_s);
        end else if (rep_fire_s) begin
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
        if (deb_upd_s) begin
            pressed_d = |snap_merged_s;
        end else begin
            pressed_d = pressed_q;
        end
    end

    // State and output registers, including the 2-flop row synchroniser.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            div_q      <= '0;
            col_idx_q  <= '0;
            col_q      <= ~COLS'(1);
            snap_q     <= '0;
            prev_q     <= '0;
            stable_q   <= 4'd0;
            deb_q      <= '0;
            key_q      <= 4'd0;
            valid_q    <= 1'b0;
            pressed_q  <= 1'b0;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;
            div_q      <= div_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            snap_q     <= snap_d;
            prev_q     <= prev_d;
            stable_q   <= stable_d;
            deb_q      <= deb_d;
            key_q      <= key_d;
            valid_q    <= valid_d;
            pressed_q  <= pressed_d;
        end
    end

    assign COL     = col_q;
    assign KEY     = key_q;
    assign VALID   = valid_q;
    assign PRESSED = pressed_q;

endmodule
